// File: rtl/ours_oursring_64_to_32_seq.sv
// Oursring 64-bit slave to 32-bit AXI-style master bridge.
// One transaction in flight; each 64-bit access is split into 32-bit halves.
package ours_oursring_pkg;
    typedef enum logic [1:0] {
        AXI4_RESP_OKAY   = 2'b00,
        AXI4_RESP_EXOKAY = 2'b01,
        AXI4_RESP_SLVERR = 2'b10,
        AXI4_RESP_DECERR = 2'b11
    } axi4_resp_t;

    typedef struct packed {
        logic [11:0] awid;
        logic [39:0] awaddr;
    } oursring_req_if_aw_t;

    typedef struct packed {
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        wlast;
    } oursring_req_if_w_t;

    typedef struct packed {
        logic [11:0] arid;
        logic [39:0] araddr;
    } oursring_req_if_ar_t;

    typedef struct packed {
        logic [11:0] rid;
        logic [63:0] rdata;
        axi4_resp_t  rresp;
        logic        rlast;
    } oursring_resp_if_r_t;

    typedef struct packed {
        logic [11:0] bid;
        axi4_resp_t  bresp;
    } oursring_resp_if_b_t;
endpackage

module ours_oursring_64_to_32_seq
    import ours_oursring_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                or_req_if_awvalid,
    output logic                or_req_if_awready,
    input  oursring_req_if_aw_t or_req_if_aw,
    input  logic                or_req_if_wvalid,
    output logic                or_req_if_wready,
    input  oursring_req_if_w_t  or_req_if_w,
    input  logic                or_req_if_arvalid,
    output logic                or_req_if_arready,
    input  oursring_req_if_ar_t or_req_if_ar,
    output logic                or_resp_if_rvalid,
    input  logic                or_resp_if_rready,
    output oursring_resp_if_r_t or_resp_if_r,
    output logic                or_resp_if_bvalid,
    input  logic                or_resp_if_bready,
    output oursring_resp_if_b_t or_resp_if_b,
    output logic                awvalid,
    input  logic                awready,
    output logic [11:0]         awid,
    output logic [39:0]         awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [11:0]         bid,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [11:0]         arid,
    output logic [39:0]         araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [11:0]         rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp
);
    typedef enum logic [2:0] {IDLE, WREQ, WRSP, BOUT, RREQ, RRSP, ROUT} state_t;

    state_t      state_q, state_d;
    logic        half_q, half_d;
    logic        last_rd_q, last_rd_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic [11:0] id_q;
    logic [39:3] addr_q;
    logic [63:0] data_q;
    logic [7:0]  strb_q;
    logic [1:0]  resp_q;
    logic [63:0] rdata_q;

    logic wr_elig, rd_elig, in_idle, gnt_wr, gnt_rd;
    logic w_first_half, need_hi, aw_acc, w_acc;

    // IP ids and wlast carry no information for this bridge.
    logic unused_ok;
    assign unused_ok = ^{bid, rid, or_req_if_w.wlast,
                         or_req_if_aw.awaddr[2:0], or_req_if_ar.araddr[2:0]};

    assign wr_elig = or_req_if_awvalid & or_req_if_wvalid;
    assign rd_elig = or_req_if_arvalid;
    assign in_idle = (state_q == IDLE) & ~rst;
    // On conflict, grant whichever side did not win last time.
    assign gnt_wr  = in_idle & wr_elig & (~rd_elig | last_rd_q);
    assign gnt_rd  = in_idle & rd_elig & ~(wr_elig & last_rd_q);

    assign w_first_half = (or_req_if_w.wstrb[3:0] == 4'h0) & (or_req_if_w.wstrb[7:4] != 4'h0);
    assign need_hi      = ~half_q & (strb_q[7:4] != 4'h0);
    assign aw_acc       = awvalid & awready;
    assign w_acc        = wvalid & wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            half_q    <= 1'b0;
            last_rd_q <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            last_rd_q <= last_rd_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        last_rd_d = last_rd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (gnt_wr) begin
                    state_d   = WREQ;
                    half_d    = w_first_half;
                    last_rd_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (gnt_rd) begin
                    state_d   = RREQ;
                    half_d    = 1'b0;
                    last_rd_d = 1'b1;
                end
            end
            WREQ: begin
                aw_done_d = aw_done_q | aw_acc;
                w_done_d  = w_done_q | w_acc;
                if ((aw_done_q | aw_acc) & (w_done_q | w_acc)) begin
                    state_d   = WRSP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WRSP: begin
                if (bvalid) begin
                    if (need_hi) begin
                        state_d = WREQ;
                        half_d  = 1'b1;
                    end else begin
                        state_d = BOUT;
                    end
                end
            end
            BOUT: begin
                if (or_resp_if_bready) begin
                    state_d = IDLE;
                    half_d  = 1'b0;
                end
            end
            RREQ: if (arready) state_d = RRSP;
            RRSP: begin
                if (rvalid) begin
                    if (!half_q) begin
                        state_d = RREQ;
                        half_d  = 1'b1;
                    end else begin
                        state_d = ROUT;
                    end
                end
            end
            ROUT: begin
                if (or_resp_if_rready) begin
                    state_d = IDLE;
                    half_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        or_req_if_awready = gnt_wr;
        or_req_if_wready  = gnt_wr;
        or_req_if_arready = gnt_rd;
        awvalid           = 1'b0;
        wvalid            = 1'b0;
        bready            = 1'b0;
        arvalid           = 1'b0;
        rready            = 1'b0;
        or_resp_if_bvalid = 1'b0;
        or_resp_if_rvalid = 1'b0;
        if (!rst) begin
            case (state_q)
                WREQ: begin
                    awvalid = ~aw_done_q;
                    wvalid  = ~w_done_q;
                end
                WRSP:    bready            = 1'b1;
                BOUT:    or_resp_if_bvalid = 1'b1;
                RREQ:    arvalid           = 1'b1;
                RRSP:    rready            = 1'b1;
                ROUT:    or_resp_if_rvalid = 1'b1;
                default: ;
            endcase
        end
    end

    // Payload capture; the merged response keeps the worst (numerically largest) beat resp.
    always_ff @(posedge clk) begin
        if (gnt_wr) begin
            id_q   <= or_req_if_aw.awid;
            addr_q <= or_req_if_aw.awaddr[39:3];
            data_q <= or_req_if_w.wdata;
            strb_q <= or_req_if_w.wstrb;
            resp_q <= 2'b00;
        end else if (gnt_rd) begin
            id_q   <= or_req_if_ar.arid;
            addr_q <= or_req_if_ar.araddr[39:3];
            resp_q <= 2'b00;
        end
        if (state_q == WRSP && bvalid && bresp > resp_q) resp_q <= bresp;
        if (state_q == RRSP && rvalid) begin
            if (rresp > resp_q) resp_q <= rresp;
            if (half_q) rdata_q[63:32] <= rdata;
            else        rdata_q[31:0]  <= rdata;
        end
    end

    assign awid   = id_q;
    assign awaddr = {addr_q, half_q, 2'b00};
    assign wdata  = half_q ? data_q[63:32] : data_q[31:0];
    assign wstrb  = half_q ? strb_q[7:4] : strb_q[3:0];
    assign arid   = id_q;
    assign araddr = {addr_q, half_q, 2'b00};

    assign or_resp_if_b.bid   = id_q;
    assign or_resp_if_b.bresp = axi4_resp_t'(resp_q);
    assign or_resp_if_r.rid   = id_q;
    assign or_resp_if_r.rdata = rdata_q;
    assign or_resp_if_r.rresp = axi4_resp_t'(resp_q);
    assign or_resp_if_r.rlast = 1'b1;
endmodule

// File: tb/tb_ours_oursring_64_to_32_seq.sv
// Bench for the 64-to-32 bridge: random IP-side slave, scoreboard of expected
// 32-bit beats built from the upstream request, merged-response checks.
module tb_ours_oursring_64_to_32_seq;
    import ours_oursring_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic or_req_if_awvalid = 0, or_req_if_awready;
    logic or_req_if_wvalid = 0, or_req_if_wready;
    logic or_req_if_arvalid = 0, or_req_if_arready;
    oursring_req_if_aw_t or_req_if_aw = '0;
    oursring_req_if_w_t  or_req_if_w = '0;
    oursring_req_if_ar_t or_req_if_ar = '0;
    logic or_resp_if_rvalid, or_resp_if_rready = 0;
    logic or_resp_if_bvalid, or_resp_if_bready = 0;
    oursring_resp_if_r_t or_resp_if_r;
    oursring_resp_if_b_t or_resp_if_b;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [11:0] awid, arid, bid, rid;
    logic [39:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    ours_oursring_64_to_32_seq dut (
        .clk(clk), .rst(rst),
        .or_req_if_awvalid(or_req_if_awvalid), .or_req_if_awready(or_req_if_awready),
        .or_req_if_aw(or_req_if_aw),
        .or_req_if_wvalid(or_req_if_wvalid), .or_req_if_wready(or_req_if_wready),
        .or_req_if_w(or_req_if_w),
        .or_req_if_arvalid(or_req_if_arvalid), .or_req_if_arready(or_req_if_arready),
        .or_req_if_ar(or_req_if_ar),
        .or_resp_if_rvalid(or_resp_if_rvalid), .or_resp_if_rready(or_resp_if_rready),
        .or_resp_if_r(or_resp_if_r),
        .or_resp_if_bvalid(or_resp_if_bvalid), .or_resp_if_bready(or_resp_if_bready),
        .or_resp_if_b(or_resp_if_b),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp)
    );

    typedef struct packed { logic [11:0] id; logic [39:0] addr; } abeat_t;
    typedef struct packed { logic [31:0] d; logic [3:0] s; } wbeat_t;

    int n_chk = 0, n_fail = 0, cyc = 0;
    abeat_t exp_aw_q[$], exp_ar_q[$];
    wbeat_t exp_w_q[$];
    logic [1:0]  force_resp_q[$];
    logic [31:0] force_rdata_q[$];
    logic [31:0] rd_words[$];
    logic [1:0]  acc_resp = 2'b00;
    int rdy_pct = 100, aw_block = 0, b_hold = 0;
    bit r_hold = 0, model_last_rd = 1, ip_bf = 0, ip_rf = 0;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    int t_gnt = 0, last_lat = 0;
    logic [39:0] ip_last_awaddr;
    logic [31:0] ip_last_wdata;
    logic [3:0]  ip_last_wstrb;
    oursring_resp_if_b_t last_b;
    oursring_resp_if_r_t last_r;
    abeat_t ea;
    wbeat_t ew;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Expected 32-bit beats of a write: needed halves lo first, a lone zero-strobe lo beat if none.
    function automatic void push_wr(input oursring_req_if_aw_t a, input oursring_req_if_w_t w);
        abeat_t ab;
        wbeat_t wb;
        for (int h = 0; h < 2; h++) begin
            logic [3:0] s;
            s = 4'(w.wstrb >> (4 * h));
            if (s != 4'h0 || (h == 0 && w.wstrb == 8'h00)) begin
                ab.id   = a.awid;
                ab.addr = {a.awaddr[39:3], 3'b000} + 40'(4 * h);
                wb.d    = 32'(w.wdata >> (32 * h));
                wb.s    = s;
                exp_aw_q.push_back(ab);
                exp_w_q.push_back(wb);
            end
        end
    endfunction

    function automatic void push_rd(input oursring_req_if_ar_t r);
        abeat_t ab;
        for (int h = 0; h < 2; h++) begin
            ab.id   = r.arid;
            ab.addr = {r.araddr[39:3], 3'b000} + 40'(4 * h);
            exp_ar_q.push_back(ab);
        end
    endfunction

    // IP-side slave: random readies, one response per accepted request.
    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0;
        forever begin
            @(negedge clk);
            if (ip_bf) bvalid = 1'b0;
            if (ip_rf) rvalid = 1'b0;
            ip_bf = 0;
            ip_rf = 0;
            awready = (aw_block == 0) && (int'($urandom_range(1, 100)) <= rdy_pct);
            if (aw_block > 0) aw_block--;
            wready  = int'($urandom_range(1, 100)) <= rdy_pct;
            arready = int'($urandom_range(1, 100)) <= rdy_pct;
            if (!bvalid && aw_n > b_n && w_n > b_n && int'($urandom_range(1, 100)) <= rdy_pct) begin
                bvalid = 1'b1;
                bid    = 12'($urandom);
                bresp  = (force_resp_q.size() > 0) ? force_resp_q.pop_front() : 2'($urandom);
            end
            if (!rvalid && !r_hold && ar_n > r_n && int'($urandom_range(1, 100)) <= rdy_pct) begin
                rvalid = 1'b1;
                rid    = 12'($urandom);
                rresp  = (force_resp_q.size() > 0) ? force_resp_q.pop_front() : 2'($urandom);
                rdata  = (force_rdata_q.size() > 0) ? force_rdata_q.pop_front() : $urandom;
            end
            #1;
            if (awvalid && awready) begin
                aw_n++;
                ip_last_awaddr = awaddr;
                if (exp_aw_q.size() == 0) chk("aw_extra", 64'(awvalid), 64'd0);
                else begin
                    ea = exp_aw_q.pop_front();
                    chk("awaddr", 64'(awaddr), 64'(ea.addr));
                    chk("awid", 64'(awid), 64'(ea.id));
                end
            end
            if (wvalid && wready) begin
                w_n++;
                ip_last_wdata = wdata;
                ip_last_wstrb = wstrb;
                if (exp_w_q.size() == 0) chk("w_extra", 64'(wvalid), 64'd0);
                else begin
                    ew = exp_w_q.pop_front();
                    chk("wdata", 64'(wdata), 64'(ew.d));
                    chk("wstrb", 64'(wstrb), 64'(ew.s));
                end
            end
            if (arvalid && arready) begin
                ar_n++;
                if (exp_ar_q.size() == 0) chk("ar_extra", 64'(arvalid), 64'd0);
                else begin
                    ea = exp_ar_q.pop_front();
                    chk("araddr", 64'(araddr), 64'(ea.addr));
                    chk("arid", 64'(arid), 64'(ea.id));
                end
            end
            if (bvalid && bready) begin
                b_n++;
                if (bresp > acc_resp) acc_resp = bresp;
                ip_bf = 1;
            end
            if (rvalid && rready) begin
                r_n++;
                if (rresp > acc_resp) acc_resp = rresp;
                rd_words.push_back(rdata);
                ip_rf = 1;
            end
        end
    end

    task automatic run_txn(input bit dw, input bit dr, input oursring_req_if_aw_t a,
                           input oursring_req_if_w_t w, input oursring_req_if_ar_t r);
        bit w_pend, r_pend, b_wait, r_wait, b_seen;
        int n;
        w_pend = dw; r_pend = dr; b_wait = dw; r_wait = dr; b_seen = 0; n = 0;
        or_req_if_aw = a;
        or_req_if_w  = w;
        or_req_if_ar = r;
        while ((w_pend || r_pend || b_wait || r_wait) && n < 300) begin
            @(negedge clk);
            n++;
            or_req_if_awvalid = w_pend;
            or_req_if_wvalid  = w_pend;
            or_req_if_arvalid = r_pend;
            or_resp_if_bready = (b_hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            or_resp_if_rready = ($urandom_range(0, 3) != 0);
            #1;
            if (w_pend && r_pend && (or_req_if_awready || or_req_if_arready))
                chk("gnt_order", 64'(or_req_if_awready), 64'(model_last_rd));
            if (w_pend && or_req_if_awready) begin
                chk("wready_pair", 64'(or_req_if_wready), 64'd1);
                push_wr(a, w);
                model_last_rd = 0;
                w_pend = 0;
                t_gnt = cyc;
            end else if (r_pend && or_req_if_arready) begin
                push_rd(r);
                model_last_rd = 1;
                r_pend = 0;
            end
            if (or_resp_if_bvalid) begin
                if (!b_wait || w_pend) chk("b_spurious", 64'(or_resp_if_bvalid), 64'd0);
                else begin
                    if (!b_seen) begin
                        b_seen = 1;
                        last_lat = cyc - t_gnt;
                    end
                    chk("bid", 64'(or_resp_if_b.bid), 64'(a.awid));
                    chk("bresp", 64'(or_resp_if_b.bresp), 64'(acc_resp));
                    chk("b_beats_left", 64'(exp_aw_q.size() + exp_w_q.size()), 64'd0);
                    if (b_hold > 0) b_hold--;
                    if (or_resp_if_bready) begin
                        b_wait = 0;
                        last_b = or_resp_if_b;
                        acc_resp = 2'b00;
                    end
                end
            end
            if (or_resp_if_rvalid) begin
                if (!r_wait || r_pend) chk("r_spurious", 64'(or_resp_if_rvalid), 64'd0);
                else begin
                    chk("rid", 64'(or_resp_if_r.rid), 64'(r.arid));
                    chk("rresp", 64'(or_resp_if_r.rresp), 64'(acc_resp));
                    chk("rlast", 64'(or_resp_if_r.rlast), 64'd1);
                    chk("r_words", 64'(rd_words.size()), 64'd2);
                    if (rd_words.size() == 2)
                        chk("rdata", or_resp_if_r.rdata, {rd_words[1], rd_words[0]});
                    chk("r_beats_left", 64'(exp_ar_q.size()), 64'd0);
                    if (or_resp_if_rready) begin
                        r_wait = 0;
                        last_r = or_resp_if_r;
                        acc_resp = 2'b00;
                        rd_words.delete();
                    end
                end
            end
        end
        chk("txn_done", 64'({w_pend, r_pend, b_wait, r_wait}), 64'd0);
        @(negedge clk);
        or_req_if_awvalid = 0;
        or_req_if_wvalid  = 0;
        or_req_if_arvalid = 0;
        or_resp_if_bready = 0;
        or_resp_if_rready = 0;
    endtask

    function automatic logic [9:0] hs_vec();
        return {or_req_if_awready, or_req_if_wready, or_req_if_arready, or_resp_if_rvalid,
                or_resp_if_bvalid, awvalid, wvalid, bready, arvalid, rready};
    endfunction

    oursring_req_if_aw_t ta;
    oursring_req_if_w_t  tw;
    oursring_req_if_ar_t tr;
    int n0;
    bit got;

    initial begin
        // Reset with every upstream valid/ready asserted: nothing may handshake.
        or_req_if_awvalid = 1; or_req_if_wvalid = 1; or_req_if_arvalid = 1;
        or_resp_if_bready = 1; or_resp_if_rready = 1;
        repeat (3) @(negedge clk);
        #1 chk("rst_hs", 64'(hs_vec()), 64'd0);
        @(negedge clk);
        or_req_if_awvalid = 0; or_req_if_wvalid = 0; or_req_if_arvalid = 0;
        or_resp_if_bready = 0; or_resp_if_rready = 0;
        rst = 0;

        // Write eligibility needs both awvalid and wvalid.
        @(negedge clk);
        or_req_if_awvalid = 1;
        #1 chk("elig_aw_only", 64'({or_req_if_awready, or_req_if_wready}), 64'd0);
        @(negedge clk);
        or_req_if_awvalid = 0; or_req_if_wvalid = 1;
        #1 chk("elig_w_only", 64'({or_req_if_awready, or_req_if_wready}), 64'd0);
        @(negedge clk);
        or_req_if_wvalid = 0;

        // Single lo half, zero-wait IP.
        rdy_pct = 100;
        force_resp_q.push_back(2'b00);
        ta = '{awid: 12'h011, awaddr: 40'h100};
        tw = '{wdata: 64'h11112222_33334444, wstrb: 8'h0F, wlast: 1'b1};
        tr = '0;
        n0 = aw_n;
        run_txn(1, 0, ta, tw, tr);
        chk("lo_beats", 64'(aw_n - n0), 64'd1);
        chk("lo_awaddr", 64'(ip_last_awaddr), 64'h100);
        chk("lo_wdata", 64'(ip_last_wdata), 64'h33334444);
        chk("lo_wstrb", 64'(ip_last_wstrb), 64'hF);
        chk("lo_bresp", 64'(last_b.bresp), 64'd0);
        chk("lat_single", 64'(last_lat), 64'd3);

        // Two halves, second beat errors.
        force_resp_q.push_back(2'b00);
        force_resp_q.push_back(2'b10);
        ta = '{awid: 12'h5A5, awaddr: 40'h108};
        tw = '{wdata: 64'hDEADBEEF_CAFEF00D, wstrb: 8'hFF, wlast: 1'b1};
        n0 = aw_n;
        run_txn(1, 0, ta, tw, tr);
        chk("full_beats", 64'(aw_n - n0), 64'd2);
        chk("full_hi_addr", 64'(ip_last_awaddr), 64'h10C);
        chk("full_bresp", 64'(last_b.bresp), 64'd2);
        chk("full_bid", 64'(last_b.bid), 64'h5A5);

        // Read with fixed data.
        force_resp_q.push_back(2'b00);
        force_resp_q.push_back(2'b00);
        force_rdata_q.push_back(32'hAAAA0000);
        force_rdata_q.push_back(32'hBBBB1111);
        tr = '{arid: 12'h077, araddr: 40'h200};
        run_txn(0, 1, ta, tw, tr);
        chk("rd_data", last_r.rdata, 64'hBBBB1111_AAAA0000);
        chk("rd_rlast", 64'(last_r.rlast), 64'd1);
        chk("rd_rresp", 64'(last_r.rresp), 64'd0);

        // Conflicts: write wins after a read, read wins after a write.
        ta = '{awid: 12'h101, awaddr: 40'h400};
        tw = '{wdata: 64'h0123_4567_89AB_CDEF, wstrb: 8'hF0, wlast: 1'b1};
        tr = '{arid: 12'h202, araddr: 40'h404};
        run_txn(1, 1, ta, tw, tr);
        run_txn(1, 0, ta, tw, tr);
        run_txn(1, 1, ta, tw, tr);

        // awready stalled while the data beat is taken early; zero strobe write.
        aw_block = 5;
        ta = '{awid: 12'h303, awaddr: 40'h50C};
        tw = '{wdata: 64'h5555_6666_7777_8888, wstrb: 8'h00, wlast: 1'b1};
        n0 = w_n;
        run_txn(1, 0, ta, tw, tr);
        chk("stall_w_beats", 64'(w_n - n0), 64'd1);
        chk("zero_wstrb", 64'(ip_last_wstrb), 64'd0);

        // Response held off upstream; payload must stay put.
        b_hold = 4;
        rdy_pct = 70;
        ta = '{awid: 12'h404, awaddr: 40'h600};
        tw = '{wdata: 64'h1, wstrb: 8'h3C, wlast: 1'b1};
        run_txn(1, 0, ta, tw, tr);

        // Reset in RRSP abandons the read.
        rdy_pct = 100;
        r_hold = 1;
        tr = '{arid: 12'h321, araddr: 40'h300};
        got = 0; n0 = 0;
        @(negedge clk);
        or_req_if_ar = tr;
        or_req_if_arvalid = 1;
        while (!got && n0 < 50) begin
            #1;
            if (or_req_if_arready) begin
                got = 1;
                push_rd(tr);
                model_last_rd = 1;
            end
            @(negedge clk);
            n0++;
        end
        or_req_if_arvalid = 0;
        chk("rst_rd_gnt", 64'(got), 64'd1);
        got = 0; n0 = 0;
        while (!got && n0 < 50) begin
            #1;
            if (rready) got = 1;
            else begin
                @(negedge clk);
                n0++;
            end
        end
        chk("rst_in_rrsp", 64'(rready), 64'd1);
        rst = 1;
        or_req_if_awvalid = 1; or_req_if_wvalid = 1; or_req_if_arvalid = 1;
        #1 chk("rst_mid_hs", 64'(hs_vec()), 64'd0);
        @(negedge clk);
        #1 chk("rst_hold_hs", 64'(hs_vec()), 64'd0);
        @(negedge clk);
        or_req_if_awvalid = 0; or_req_if_wvalid = 0; or_req_if_arvalid = 0;
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        rd_words.delete(); force_resp_q.delete(); force_rdata_q.delete();
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        acc_resp = 2'b00; model_last_rd = 1; r_hold = 0;
        rst = 0;
        or_resp_if_rready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rst_no_rvalid", 64'(or_resp_if_rvalid), 64'd0);
        end
        or_resp_if_rready = 0;
        force_rdata_q.push_back(32'h0000CAFE);
        force_rdata_q.push_back(32'hBEEF0000);
        tr = '{arid: 12'h654, araddr: 40'h308};
        run_txn(0, 1, ta, tw, tr);
        chk("post_rst_rdata", last_r.rdata, 64'hBEEF0000_0000CAFE);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 40; i++) begin
            int kind;
            rdy_pct = $urandom_range(40, 100);
            kind = $urandom_range(0, 2);
            ta.awid   = 12'($urandom);
            ta.awaddr = {8'($urandom), $urandom};
            tw.wdata  = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       tw.wstrb = 8'h00;
                1:       tw.wstrb = 8'h0F;
                2:       tw.wstrb = 8'hF0;
                default: tw.wstrb = 8'($urandom);
            endcase
            tw.wlast  = 1'($urandom);
            tr.arid   = 12'($urandom);
            tr.araddr = {8'($urandom), $urandom};
            run_txn(kind != 1, kind != 0, ta, tw, tr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
